// File: rtl/rvga_icache.sv
// rvga_icache -- direct-mapped, blocking, read-only instruction cache.
//
// Sits between the core's fetch port and a backing memory. Hits answer in the
// same cycle. A miss issues one line-fill request, collects WORDS_PER_LINE
// sequential 32-bit beats, installs the line and then re-runs the lookup.
// flush_i invalidates every line (fence.i).
//
// Ports:
//   clk_i            clock
//   rst_i            asynchronous, active-high reset
//   imem_v_i         fetch request valid
//   imem_addr_i      fetch byte address (bits [1:0] ignored)
//   imem_data_o      fetched instruction (0 when imem_resp_v_o is low)
//   imem_resp_v_o    imem_data_o is valid this cycle
//   flush_i          invalidate all lines
//   mem_req_v_o      line-fill request valid
//   mem_req_ready_i  memory accepts the request
//   mem_addr_o       line-aligned fill address
//   mem_resp_v_i     fill beat valid
//   mem_data_i       fill beat data, word 0 first
module rvga_icache #(
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_v_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_resp_v_o,
  input  logic        flush_i,
  output logic        mem_req_v_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_v_i,
  input  logic [31:0] mem_data_i
);

  localparam int O  = $clog2(WORDS_PER_LINE);
  localparam int I  = $clog2(SETS);
  localparam int TW = 30 - O - I;
  localparam logic [O-1:0] LAST_BEAT = O'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL} state_e;

  state_e            state_q;
  logic [SETS-1:0]   valid_q;
  logic [TW-1:0]     tag_q  [SETS];
  logic [31:0]       data_q [SETS][WORDS_PER_LINE];
  logic [29-O:0]     miss_hi_q;      // {tag, index} of the line being filled
  logic [O-1:0]      cnt_q;
  logic              flush_pending_q;
  logic              mem_req_v_q;
  logic [31:0]       mem_addr_q;

  // Lookup fields of the current fetch address.
  logic [O-1:0]  off;
  logic [I-1:0]  idx;
  logic [TW-1:0] tag;
  assign off = imem_addr_i[2+O-1:2];
  assign idx = imem_addr_i[2+O+I-1:2+O];
  assign tag = imem_addr_i[31:2+O+I];

  // Byte-select bits never matter for 32-bit fetches.
  logic unused_byte_bits;
  assign unused_byte_bits = ^imem_addr_i[1:0];

  // Fields of the line being filled, taken from the latched miss address so
  // later changes of imem_addr_i cannot redirect the fill.
  logic [I-1:0]  miss_idx;
  logic [TW-1:0] miss_tag;
  assign miss_idx = miss_hi_q[I-1:0];
  assign miss_tag = miss_hi_q[29-O:I];

  // A flush in the same cycle suppresses the hit so the core refetches after
  // fence.i instead of consuming a line that is about to disappear.
  logic hit;
  assign hit = (state_q == IDLE) && imem_v_i && !flush_i &&
               valid_q[idx] && (tag_q[idx] == tag);

  assign imem_resp_v_o = hit;
  assign imem_data_o   = hit ? data_q[idx][off] : 32'h0;
  assign mem_req_v_o   = mem_req_v_q;
  assign mem_addr_o    = mem_addr_q;

  logic fill_beat;
  logic last_beat;
  assign fill_beat = (state_q == FILL) && mem_resp_v_i;
  assign last_beat = fill_beat && (cnt_q == LAST_BEAT);

  // NOTE: every state register is updated with <= so all of them see the
  // pre-edge values of each other regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      miss_hi_q       <= '0;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
      mem_req_v_q     <= 1'b0;
      mem_addr_q      <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            valid_q <= '0;
          end else if (imem_v_i && !hit) begin
            state_q     <= REQ;
            miss_hi_q   <= imem_addr_i[31:2+O];
            mem_req_v_q <= 1'b1;
            mem_addr_q  <= {imem_addr_i[31:2+O], {(O+2){1'b0}}};
          end
        end
        REQ: begin
          if (flush_i) flush_pending_q <= 1'b1;
          if (mem_req_ready_i) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            mem_req_v_q <= 1'b0;
            mem_addr_q  <= 32'h0;
          end
        end
        FILL: begin
          if (flush_i) flush_pending_q <= 1'b1;
          if (mem_resp_v_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_q         <= IDLE;
              flush_pending_q <= 1'b0;
              // A flush seen at any point during the fill, including this
              // final beat, also wipes the freshly filled line.
              if (flush_pending_q || flush_i) valid_q <= '0;
              else                            valid_q[miss_idx] <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; valid_q alone decides whether
  // their contents are meaningful, so resetting them would only add muxing.
  always_ff @(posedge clk_i) begin
    if (fill_beat) data_q[miss_idx][cnt_q] <= mem_data_i;
    if (last_beat) tag_q[miss_idx]         <= miss_tag;
  end

endmodule

// File: doc/rvga_icache.md
Name: rvga_icache

Overview:
- Direct-mapped, blocking, read-only instruction cache between the core's fetch interface (imem_addr/imem_data/imem_resp_v) and a backing memory.
- Hits answer in the same cycle.
- Misses issue one line-fill request and receive WORDS_PER_LINE sequential 32-bit beats. The line is then installed and the pending fetch hits.
- flush_i invalidates all lines, for fence.i.

Parameters:
- SETS, 64, number of lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- imem_v_i  in  1  fetch request valid; the core ties it to 1
- imem_addr_i  in  32  fetch byte address; bits [1:0] are ignored
- imem_data_o  out  32  fetched instruction
- imem_resp_v_o  out  1  imem_data_o is valid this cycle
- flush_i  in  1  invalidate all lines
- mem_req_v_o  out  1  line-fill request valid
- mem_req_ready_i  in  1  memory accepts the request
- mem_addr_o  out  32  line-aligned fill address
- mem_resp_v_i  in  1  fill beat valid
- mem_data_i  in  32  fill beat data, in word order 0..WORDS_PER_LINE-1

Behaviour:
- Address split, with O = log2(WORDS_PER_LINE) and I = log2(SETS):
  - word offset = addr[2+O-1:2]
  - index = addr[2+O+I-1:2+O]
  - tag = addr[31:2+O+I]
- Storage is flop arrays: valid[SETS], tag[SETS], data[SETS][WORDS_PER_LINE].
- FSM states: IDLE, REQ, FILL.
- Hit is combinational: state==IDLE and imem_v_i and valid[index] and tag match.
  - On a hit: imem_resp_v_o=1 and imem_data_o=word in the same cycle.
  - Otherwise: imem_resp_v_o=0 and imem_data_o=0.
- IDLE, with imem_v_i and a miss and no flush_i:
  - Go to REQ.
  - Latch miss_line = {imem_addr_i[31:2+O], O+2 zero bits}.
- REQ:
  - mem_req_v_o=1 and mem_addr_o=miss_line, both held stable until mem_req_ready_i.
  - On handshake: go to FILL and set beat counter = 0.
- FILL:
  - Each mem_resp_v_i writes mem_data_i to data[miss index][counter], then increments the counter.
  - On the beat where counter==WORDS_PER_LINE-1: write tag, set valid unless a flush is pending, go to IDLE.
  - Return to IDLE is the next cycle; the lookup is then re-evaluated against the current imem_addr_i.
- mem_resp_v_i is ignored in IDLE and REQ.
- Changes to imem_addr_i during REQ or FILL do not alter the fill in progress.
- imem_resp_v_o=0 in REQ and FILL, including the cycle of the final beat.
- flush_i in IDLE:
  - All valid bits are cleared at the next edge.
  - A miss in that same cycle is not started; imem_resp_v_o is forced to 0 in that cycle.
- flush_i in REQ or FILL:
  - Sets flush_pending; the fill completes normally.
  - On completion all valid bits are cleared (the filled line included) and flush_pending is cleared.
- Simultaneous final beat and flush_i: treated as pending flush; the line ends invalid.
- Reset, including mid-fill, takes effect immediately and asynchronously:
  - state=IDLE, all valid=0, counter=0, flush_pending=0, miss_line=0.
  - mem_req_v_o=0, mem_addr_o=0, imem_resp_v_o=0, imem_data_o=0.
  - Stray beats arriving after reset are ignored.
- There is no replacement choice: a miss overwrites the indexed line.

Test Plan (defaults SETS=64, WORDS_PER_LINE=4):
1. Reset, then imem_addr_i=0x100 -> imem_resp_v_o=0, mem_req_v_o=1, mem_addr_o=0x100. Ready 1 cycle later, beats 0x11/0x22/0x33/0x44. The cycle after the last beat: resp_v=1, data=0x11. Then addr 0x10C -> same-cycle hit, data 0x44.
2. Conflict: line 0x100 cached, fetch 0x500 (same index, tag 1) -> miss with mem_addr_o=0x500, refill. Then 0x100 misses again.
3. Backpressure: mem_req_ready_i held 0 for 5 cycles -> mem_req_v_o=1 and mem_addr_o=0x100 stable throughout. No state change while imem_addr_i toggles to 0x200.
4. Flush: after a hit at 0x100, flush_i for 1 cycle -> resp_v=0 that cycle, then a miss at 0x100. Separately, flush_i during FILL beat 1 -> fill completes, the next lookup at 0x100 misses.
5. Reset mid-fill after 2 beats -> all outputs 0 immediately. Two further mem_resp_v_i beats are ignored. The next fetch at 0x100 requests a refill, written from word 0.
6. imem_v_i=0 with a missing address -> mem_req_v_o stays 0 and resp_v=0.
